// File: rtl/stg_wb_fwd_pkg.sv
// Shared sizes and helpers for the writeback/forwarding stage.
package stg_wb_fwd_pkg;

  localparam int SIZE_ADDR     = 24;
  localparam int SIZE_DATA     = 24;
  localparam int SIZE_OPC      = 8;
  localparam int SIZE_TGT_GP   = 4;
  localparam int SIZE_TGT_SR   = 2;
  localparam int HIST_DEPTH_WB = 2;
  localparam int SIZE_RCNT     = 32;

  // Flush and stall both kill the commit; flush wins when both are set.
  function automatic logic commit_qual(input logic valid, input logic stall, input logic flush);
    return valid & ~flush & ~stall;
  endfunction

endpackage

// File: rtl/wb_fwd_hist.sv
// Committed-write history (entry 0 newest) with a combinational
// priority lookup: current write first, then entry 0, 1, ...
module wb_fwd_hist
  import stg_wb_fwd_pkg::*;
#(
  parameter int IDX_W  = SIZE_TGT_GP,
  parameter int DATA_W = SIZE_DATA,
  parameter int DEPTH  = HIST_DEPTH_WB
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_shift,
  input  logic              iw_cur_we,
  input  logic [IDX_W-1:0]  iw_cur_idx,
  input  logic [DATA_W-1:0] iw_cur_data,
  input  logic [IDX_W-1:0]  iw_look_idx,
  output logic              ow_hit,
  output logic [DATA_W-1:0] ow_data
);

  logic              r_we   [DEPTH];
  logic [IDX_W-1:0]  r_idx  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Shift a new entry in on every commit, even one that writes nothing.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_we[i]   <= 1'b0;
        r_idx[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (iw_shift) begin
      r_we[0]   <= iw_cur_we;
      r_idx[0]  <= iw_cur_idx;
      r_data[0] <= iw_cur_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_we[i]   <= r_we[i-1];
        r_idx[i]  <= r_idx[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Oldest first so that later (newer) matches override earlier ones.
  always_comb begin
    ow_hit  = 1'b0;
    ow_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_we[i] && (r_idx[i] == iw_look_idx)) begin
        ow_hit  = 1'b1;
        ow_data = r_data[i];
      end
    end
    if (iw_cur_we && (iw_cur_idx == iw_look_idx)) begin
      ow_hit  = 1'b1;
      ow_data = iw_cur_data;
    end
  end

endmodule

// File: rtl/stg_wb_fwd.sv
// Writeback stage: regfile write ports, GP/SR forwarding history,
// trace latches and retire counter.
module stg_wb_fwd
  import stg_wb_fwd_pkg::*;
#(
  parameter int ADDR_W     = SIZE_ADDR,
  parameter int DATA_W     = SIZE_DATA,
  parameter int OPC_W      = SIZE_OPC,
  parameter int TGT_GP_W   = SIZE_TGT_GP,
  parameter int TGT_SR_W   = SIZE_TGT_SR,
  parameter int HIST_DEPTH = HIST_DEPTH_WB,
  parameter int RCNT_W     = SIZE_RCNT
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_valid,
  input  logic                iw_stall,
  input  logic                iw_flush,
  input  logic [ADDR_W-1:0]   iw_pc,
  input  logic [DATA_W-1:0]   iw_instr,
  input  logic [OPC_W-1:0]    iw_opc,
  input  logic [TGT_GP_W-1:0] iw_tgt_gp,
  input  logic                iw_tgt_gp_we,
  input  logic [TGT_SR_W-1:0] iw_tgt_sr,
  input  logic                iw_tgt_sr_we,
  input  logic [DATA_W-1:0]   iw_result,
  output logic [TGT_GP_W-1:0] ow_gp_write_addr,
  output logic [DATA_W-1:0]   ow_gp_write_data,
  output logic                ow_gp_write_enable,
  output logic [TGT_SR_W-1:0] ow_sr_write_addr,
  output logic [DATA_W-1:0]   ow_sr_write_data,
  output logic                ow_sr_write_enable,
  input  logic [TGT_GP_W-1:0] iw_fwd_gp_addr,
  output logic                ow_fwd_gp_hit,
  output logic [DATA_W-1:0]   ow_fwd_gp_data,
  input  logic [TGT_SR_W-1:0] iw_fwd_sr_addr,
  output logic                ow_fwd_sr_hit,
  output logic [DATA_W-1:0]   ow_fwd_sr_data,
  output logic                ow_valid,
  output logic [ADDR_W-1:0]   ow_pc,
  output logic [DATA_W-1:0]   ow_instr,
  output logic [OPC_W-1:0]    ow_opc,
  output logic [TGT_GP_W-1:0] ow_tgt_gp,
  output logic [TGT_SR_W-1:0] ow_tgt_sr,
  output logic [DATA_W-1:0]   ow_result,
  output logic [RCNT_W-1:0]   ow_retire_cnt
);

  logic w_commit;
  logic w_gp_we;
  logic w_sr_we;

  assign w_commit = commit_qual(iw_valid, iw_stall, iw_flush);
  assign w_gp_we  = w_commit & iw_tgt_gp_we;
  assign w_sr_we  = w_commit & iw_tgt_sr_we;

  assign ow_gp_write_addr   = iw_tgt_gp;
  assign ow_gp_write_data   = iw_result;
  assign ow_gp_write_enable = w_gp_we;
  assign ow_sr_write_addr   = iw_tgt_sr;
  assign ow_sr_write_data   = iw_result;
  assign ow_sr_write_enable = w_sr_we;

  wb_fwd_hist #(.IDX_W(TGT_GP_W), .DATA_W(DATA_W), .DEPTH(HIST_DEPTH)) u_hist_gp (
    .iw_clk      (iw_clk),
    .iw_rst      (iw_rst),
    .iw_shift    (w_commit),
    .iw_cur_we   (w_gp_we),
    .iw_cur_idx  (iw_tgt_gp),
    .iw_cur_data (iw_result),
    .iw_look_idx (iw_fwd_gp_addr),
    .ow_hit      (ow_fwd_gp_hit),
    .ow_data     (ow_fwd_gp_data)
  );

  wb_fwd_hist #(.IDX_W(TGT_SR_W), .DATA_W(DATA_W), .DEPTH(HIST_DEPTH)) u_hist_sr (
    .iw_clk      (iw_clk),
    .iw_rst      (iw_rst),
    .iw_shift    (w_commit),
    .iw_cur_we   (w_sr_we),
    .iw_cur_idx  (iw_tgt_sr),
    .iw_cur_data (iw_result),
    .iw_look_idx (iw_fwd_sr_addr),
    .ow_hit      (ow_fwd_sr_hit),
    .ow_data     (ow_fwd_sr_data)
  );

  logic                r_valid;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_instr;
  logic [OPC_W-1:0]    r_opc;
  logic [TGT_GP_W-1:0] r_tgt_gp;
  logic [TGT_SR_W-1:0] r_tgt_sr;
  logic [DATA_W-1:0]   r_result;
  logic [RCNT_W-1:0]   r_retire_cnt;

  // Trace latches: flag every cycle, payload only on commit; counter wraps.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_opc        <= '0;
      r_tgt_gp     <= '0;
      r_tgt_sr     <= '0;
      r_result     <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_pc         <= iw_pc;
        r_instr      <= iw_instr;
        r_opc        <= iw_opc;
        r_tgt_gp     <= iw_tgt_gp;
        r_tgt_sr     <= iw_tgt_sr;
        r_result     <= iw_result;
        r_retire_cnt <= r_retire_cnt + RCNT_W'(1);
      end
    end
  end

  assign ow_valid      = r_valid;
  assign ow_pc         = r_pc;
  assign ow_instr      = r_instr;
  assign ow_opc        = r_opc;
  assign ow_tgt_gp     = r_tgt_gp;
  assign ow_tgt_sr     = r_tgt_sr;
  assign ow_result     = r_result;
  assign ow_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_stg_wb_fwd.sv
// Directed plus randomized bench for stg_wb_fwd against a queue-based model.
module tb_stg_wb_fwd;

  localparam int AW = 24;
  localparam int DW = 24;
  localparam int OW = 8;
  localparam int GW = 4;
  localparam int SW = 2;
  localparam int HD = 2;
  localparam int RW = 4;

  logic          iw_clk = 1'b0;
  logic          iw_rst = 1'b1;
  logic          iw_valid = 1'b0, iw_stall = 1'b0, iw_flush = 1'b0;
  logic [AW-1:0] iw_pc = '0;
  logic [DW-1:0] iw_instr = '0;
  logic [OW-1:0] iw_opc = '0;
  logic [GW-1:0] iw_tgt_gp = '0;
  logic          iw_tgt_gp_we = 1'b0;
  logic [SW-1:0] iw_tgt_sr = '0;
  logic          iw_tgt_sr_we = 1'b0;
  logic [DW-1:0] iw_result = '0;
  logic [GW-1:0] iw_fwd_gp_addr = '0;
  logic [SW-1:0] iw_fwd_sr_addr = '0;

  logic [GW-1:0] ow_gp_write_addr;
  logic [DW-1:0] ow_gp_write_data;
  logic          ow_gp_write_enable;
  logic [SW-1:0] ow_sr_write_addr;
  logic [DW-1:0] ow_sr_write_data;
  logic          ow_sr_write_enable;
  logic          ow_fwd_gp_hit;
  logic [DW-1:0] ow_fwd_gp_data;
  logic          ow_fwd_sr_hit;
  logic [DW-1:0] ow_fwd_sr_data;
  logic          ow_valid;
  logic [AW-1:0] ow_pc;
  logic [DW-1:0] ow_instr;
  logic [OW-1:0] ow_opc;
  logic [GW-1:0] ow_tgt_gp;
  logic [SW-1:0] ow_tgt_sr;
  logic [DW-1:0] ow_result;
  logic [RW-1:0] ow_retire_cnt;

  stg_wb_fwd #(.ADDR_W(AW), .DATA_W(DW), .OPC_W(OW), .TGT_GP_W(GW), .TGT_SR_W(SW),
               .HIST_DEPTH(HD), .RCNT_W(RW)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_valid(iw_valid), .iw_stall(iw_stall),
    .iw_flush(iw_flush), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we), .iw_tgt_sr(iw_tgt_sr),
    .iw_tgt_sr_we(iw_tgt_sr_we), .iw_result(iw_result),
    .ow_gp_write_addr(ow_gp_write_addr), .ow_gp_write_data(ow_gp_write_data),
    .ow_gp_write_enable(ow_gp_write_enable), .ow_sr_write_addr(ow_sr_write_addr),
    .ow_sr_write_data(ow_sr_write_data), .ow_sr_write_enable(ow_sr_write_enable),
    .iw_fwd_gp_addr(iw_fwd_gp_addr), .ow_fwd_gp_hit(ow_fwd_gp_hit),
    .ow_fwd_gp_data(ow_fwd_gp_data), .iw_fwd_sr_addr(iw_fwd_sr_addr),
    .ow_fwd_sr_hit(ow_fwd_sr_hit), .ow_fwd_sr_data(ow_fwd_sr_data),
    .ow_valid(ow_valid), .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
    .ow_tgt_gp(ow_tgt_gp), .ow_tgt_sr(ow_tgt_sr), .ow_result(ow_result),
    .ow_retire_cnt(ow_retire_cnt)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct {
    logic          gwe;
    logic [GW-1:0] gt;
    logic          swe;
    logic [SW-1:0] st;
    logic [DW-1:0] d;
  } ent_t;

  ent_t hist[$];
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_instr;
  logic [OW-1:0] m_opc;
  logic [GW-1:0] m_tgt_gp;
  logic [SW-1:0] m_tgt_sr;
  logic [DW-1:0] m_result;
  int            m_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_valid = 0; m_pc = '0; m_instr = '0; m_opc = '0;
    m_tgt_gp = '0; m_tgt_sr = '0; m_result = '0; m_cnt = 0;
  endtask

  // Sources in priority order: the live commit, then history newest-first.
  task automatic ref_lookup(input logic c, input logic is_sr, input int la,
                            output logic hit, output logic [DW-1:0] data);
    hit = 0; data = '0;
    if (c && !is_sr && iw_tgt_gp_we && int'(iw_tgt_gp) == la) begin
      hit = 1; data = iw_result; return;
    end
    if (c && is_sr && iw_tgt_sr_we && int'(iw_tgt_sr) == la) begin
      hit = 1; data = iw_result; return;
    end
    foreach (hist[i]) begin
      if (!is_sr && hist[i].gwe && int'(hist[i].gt) == la) begin
        hit = 1; data = hist[i].d; return;
      end
      if (is_sr && hist[i].swe && int'(hist[i].st) == la) begin
        hit = 1; data = hist[i].d; return;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic f,
                      input logic gwe, input logic [GW-1:0] gt,
                      input logic swe, input logic [SW-1:0] st,
                      input logic [DW-1:0] res,
                      input logic [GW-1:0] lg, input logic [SW-1:0] ls);
    logic c, h;
    logic [DW-1:0] d;
    ent_t e;
    @(negedge iw_clk);
    iw_valid = v; iw_stall = s; iw_flush = f;
    iw_tgt_gp_we = gwe; iw_tgt_gp = gt; iw_tgt_sr_we = swe; iw_tgt_sr = st;
    iw_result = res; iw_fwd_gp_addr = lg; iw_fwd_sr_addr = ls;
    iw_pc = AW'($urandom); iw_instr = DW'($urandom); iw_opc = OW'($urandom);
    #1;
    c = v && !s && !f;
    chk("gp_we",   32'(ow_gp_write_enable), 32'(c && gwe));
    chk("gp_addr", 32'(ow_gp_write_addr), 32'(gt));
    chk("gp_data", 32'(ow_gp_write_data), 32'(res));
    chk("sr_we",   32'(ow_sr_write_enable), 32'(c && swe));
    chk("sr_addr", 32'(ow_sr_write_addr), 32'(st));
    chk("sr_data", 32'(ow_sr_write_data), 32'(res));
    ref_lookup(c, 1'b0, int'(lg), h, d);
    chk("fwd_gp_hit",  32'(ow_fwd_gp_hit), 32'(h));
    chk("fwd_gp_data", 32'(ow_fwd_gp_data), 32'(d));
    ref_lookup(c, 1'b1, int'(ls), h, d);
    chk("fwd_sr_hit",  32'(ow_fwd_sr_hit), 32'(h));
    chk("fwd_sr_data", 32'(ow_fwd_sr_data), 32'(d));
    @(posedge iw_clk);
    m_valid = c;
    if (c) begin
      m_pc = iw_pc; m_instr = iw_instr; m_opc = iw_opc;
      m_tgt_gp = gt; m_tgt_sr = st; m_result = res;
      m_cnt = (m_cnt + 1) % (1 << RW);
      e.gwe = gwe; e.gt = gt; e.swe = swe; e.st = st; e.d = res;
      hist.push_front(e);
      if (hist.size() > HD) void'(hist.pop_back());
    end
    #1;
    chk("ow_valid",  32'(ow_valid), 32'(m_valid));
    chk("ow_pc",     32'(ow_pc), 32'(m_pc));
    chk("ow_instr",  32'(ow_instr), 32'(m_instr));
    chk("ow_opc",    32'(ow_opc), 32'(m_opc));
    chk("ow_tgt_gp", 32'(ow_tgt_gp), 32'(m_tgt_gp));
    chk("ow_tgt_sr", 32'(ow_tgt_sr), 32'(m_tgt_sr));
    chk("ow_result", 32'(ow_result), 32'(m_result));
    chk("retire_cnt", 32'(ow_retire_cnt), 32'(m_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"},  32'(ow_valid), 32'd0);
    chk({tag, "_pc"},     32'(ow_pc), 32'd0);
    chk({tag, "_instr"},  32'(ow_instr), 32'd0);
    chk({tag, "_opc"},    32'(ow_opc), 32'd0);
    chk({tag, "_result"}, 32'(ow_result), 32'd0);
    chk({tag, "_tgts"},   32'({ow_tgt_gp, ow_tgt_sr}), 32'd0);
    chk({tag, "_cnt"},    32'(ow_retire_cnt), 32'd0);
    chk({tag, "_gphit"},  32'(ow_fwd_gp_hit), 32'd0);
    chk({tag, "_srhit"},  32'(ow_fwd_sr_hit), 32'd0);
    chk({tag, "_gpdata"}, 32'(ow_fwd_gp_data), 32'd0);
  endtask

  task automatic mid_reset();
    @(negedge iw_clk);
    iw_valid = 0; iw_stall = 0; iw_flush = 0;
    iw_fwd_gp_addr = hist.size() > 0 ? hist[0].gt : '0;
    iw_fwd_sr_addr = hist.size() > 0 ? hist[0].st : '0;
    #2 iw_rst = 1'b1;
    #1 model_reset();
    check_reset_state("midrst");
    @(negedge iw_clk);
    iw_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_state("rst");
    @(negedge iw_clk);
    iw_rst = 1'b0;

    // Basic GP commit
    step(1, 0, 0, 1, 4'd3, 0, 2'd0, 24'h00ABCD, 4'd3, 2'd0);
    chk("t1_result", 32'(ow_result), 32'h00ABCD);
    chk("t1_cnt", 32'(ow_retire_cnt), 32'd1);

    // Stall for three cycles, then release
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 4'd4, 0, 2'd0, 24'h000444, 4'd4, 2'd0);
    chk("t2_cnt_stalled", 32'(ow_retire_cnt), 32'd1);
    step(1, 0, 0, 1, 4'd4, 0, 2'd0, 24'h000444, 4'd4, 2'd0);
    chk("t2_cnt", 32'(ow_retire_cnt), 32'd2);

    // Flush with stall
    step(1, 1, 1, 1, 4'd9, 1, 2'd2, 24'h000999, 4'd9, 2'd2);
    chk("t3_valid", 32'(ow_valid), 32'd0);
    chk("t3_cnt", 32'(ow_retire_cnt), 32'd2);
    chk("t3_gp_hit", 32'(ow_fwd_gp_hit), 32'd0);

    // Newest history entry wins; ages out after two more commits
    step(1, 0, 0, 1, 4'd5, 0, 2'd0, 24'h000111, 4'd5, 2'd0);
    step(1, 0, 0, 1, 4'd5, 0, 2'd0, 24'h000222, 4'd5, 2'd0);
    step(0, 0, 0, 0, 4'd0, 0, 2'd0, 24'h0, 4'd5, 2'd0);
    chk("t4_hit", 32'(ow_fwd_gp_hit), 32'd1);
    chk("t4_data", 32'(ow_fwd_gp_data), 32'h000222);
    step(1, 0, 0, 1, 4'd6, 0, 2'd0, 24'h000666, 4'd5, 2'd0);
    step(1, 0, 0, 1, 4'd7, 0, 2'd0, 24'h000777, 4'd5, 2'd0);
    step(0, 0, 0, 0, 4'd0, 0, 2'd0, 24'h0, 4'd5, 2'd0);
    chk("t4_aged_hit", 32'(ow_fwd_gp_hit), 32'd0);

    // Current write beats history; SR-only commit
    step(1, 0, 0, 1, 4'd2, 0, 2'd0, 24'h000444, 4'd2, 2'd0);
    step(1, 0, 0, 1, 4'd2, 0, 2'd0, 24'h000333, 4'd2, 2'd0);
    chk("t5_gp_data", 32'(ow_fwd_gp_data), 32'h000333);
    step(1, 0, 0, 0, 4'd1, 1, 2'd1, 24'h000055, 4'd1, 2'd1);
    chk("t5_sr_hit", 32'(ow_fwd_sr_hit), 32'd1);
    chk("t5_sr_data", 32'(ow_fwd_sr_data), 32'h000055);
    chk("t5_gp_miss", 32'(ow_fwd_gp_hit), 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if (n % 150 == 149) mid_reset();
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1),
           1'($urandom), GW'($urandom_range(0, 5)), 1'($urandom), SW'($urandom),
           DW'($urandom), GW'($urandom_range(0, 5)), SW'($urandom));
    end

    // Counter wrap: 16 commits from reset return to zero
    mid_reset();
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 1'($urandom), GW'($urandom), 1'($urandom), SW'($urandom),
           DW'($urandom), GW'($urandom), SW'($urandom));
    chk("t6_wrap", 32'(ow_retire_cnt), 32'd0);
    step(1, 0, 0, 0, 4'd0, 0, 2'd0, 24'h0, 4'd0, 2'd0);
    chk("t6_after_wrap", 32'(ow_retire_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
